if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage for the 16-bit MIPS pipeline, sitting directly upstream of the decode/execute datapath. It owns the program counter and drives the asynchronous-read program memory. It registers the fetched 32-bit instruction and its address into the IF/ID pipeline register (`ins`, `Current_Address`). It also handles stall hold, branch redirect, and single-level interrupt entry/return with bubble insertion (`stall_pm`).

## Interface
- `RESET_VEC`, 16'h0000: PC value out of reset.
- `INT_VEC`, 16'h00F0: interrupt service routine entry address.
- `NOP`, 32'h0000_0000: instruction word injected on flush.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-low reset; while low, all state is held at reset values.
- `stall`  in  1: hazard-unit hold; freezes PC and IF/ID.
- `branch_taken`  in  1: redirect request from the resolving stage.
- `branch_target`  in  16: redirect address, valid with `branch_taken`.
- `reti`  in  1: return-from-interrupt decoded downstream, single-cycle pulse.
- `interrupt`  in  1: external asynchronous interrupt request; rising-edge sensitive.
- `pm_data`  in  32: program-memory read data, combinational from `pm_addr`.
- `pm_addr`  out  16: program-memory address, equal to PC.
- `ins`  out  32: IF/ID instruction.
- `Current_Address`  out  16: IF/ID address of `ins`.
- `stall_pm`  out  1: high while `ins` holds an injected bubble.
- `int_ack`  out  1: one-cycle pulse on interrupt entry.

## Operation
- State machine states: RUN and IN_ISR. Reset state is RUN.
- Interrupt input: 2-flop synchronizer, then rising-edge detect. An edge sets `pending`. `pending` is cleared only on entry. Edges seen while `pending` is already set are merged.
- Per-cycle priority, highest first:
  1. Reset.
  2. `branch_taken`: PC<=`branch_target`; IF/ID flushed (`ins`<=NOP, `stall_pm`<=1). Overrides `stall`.
  3. `reti` in IN_ISR: PC<=EPC; flush; state goes to RUN. `reti` in RUN is ignored.
  4. Entry, when `pending` is set, state is RUN and `stall`=0: EPC<=PC; PC<=`INT_VEC`; flush; `int_ack`<=1; `pending`<=0; state goes to IN_ISR.
  5. `stall`: PC, `ins`, `Current_Address` and `stall_pm` hold.
  6. Otherwise: `ins`<=`pm_data`, `Current_Address`<=PC, `stall_pm`<=0, PC<=PC+1.
- No nesting. A pending interrupt waits in IN_ISR and is taken on the first eligible RUN cycle after `reti`, i.e. one cycle after return.
- Branches inside the ISR behave normally; state stays IN_ISR.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000. No fault is raised.
- Reset values: PC=`RESET_VEC`, EPC=0, `ins`=NOP, `Current_Address`=0, `stall_pm`=1, `int_ack`=0, `pending`=0, sync flops=0.
- Reset asserted mid-ISR aborts the ISR. The state machine returns to RUN, and the pending interrupt and EPC are discarded.

## Timing
- Fetch latency: 1 cycle. The address on `pm_addr` in cycle n appears on `ins`/`Current_Address` after edge n.
- First valid instruction: on the first rising edge after `reset` goes high, `ins`=mem[`RESET_VEC`] and `stall_pm`=0.
- Redirect penalty (branch, entry or reti): 1 bubble cycle. `stall_pm`=1 for exactly that cycle, unless a second redirect follows.
- Interrupt latency from the `interrupt` rising edge: 2 cycles for sync, plus 1 for the edge register, then entry on the next eligible edge. Minimum latency is 3 edges to the `int_ack` pulse.
- Simultaneous events:
  - `branch_taken` and entry in the same cycle: the branch wins and entry is deferred one cycle. EPC then captures the branch target.
  - `branch_taken` and `reti` in the same cycle: the branch wins and `reti` is lost. Downstream must not issue both.
- `int_ack` is registered, high exactly one cycle.

## Structure
- Shared `mips_pkg`: `NOP` encoding, `RESET_VEC`, `INT_VEC`, and the fetch state enum (RUN, IN_ISR), so decode and the hazard unit use identical values.
- One sub-module, `int_sync_edge`: 2-flop synchronizer plus rising-edge pulse, active-low async reset. Reusable for other external inputs.
- The top-level design contains PC, EPC, state, pending, and the IF/ID register.

## Test plan
- Reset sequence: `reset`=0 for 200 ns, then 1, with mem[0]=32'h1111_0000 and mem[1]=32'h2222_0001. Required: `stall_pm`=1 and `ins`=0 during reset; after edge 1, `ins`=32'h1111_0000 and `Current_Address`=0; after edge 2, `Current_Address`=1.
- Stall: assert `stall` for 3 cycles at PC=5. Required: `pm_addr` stays 5 and `ins`/`Current_Address` hold; after release, `Current_Address`=5.
- Branch with stall at PC=8: drive `branch_target`=16'h0040. Required: next `pm_addr`=16'h0040, one bubble with `stall_pm`=1, then `Current_Address`=16'h0040.
- Interrupt: raise `interrupt` at PC=16'h0010. Required: a single `int_ack` pulse 3 edges later and `pm_addr`=16'h00F0. On `reti`, fetch resumes at the saved PC; a second edge during the ISR is taken one cycle after return.
- Wrap and mid-ISR reset:
  - Sequential fetch at 16'hFFFF: required next `pm_addr`=16'h0000.
  - Reset pulsed while IN_ISR: required PC=`RESET_VEC`, state RUN, no `int_ack` afterwards.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the 16-bit MIPS pipeline: NOP encoding,
// reset/interrupt vectors, fetch state encoding and the IF/ID payload.
package mips_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  RESET_VEC = 16'h0000;
  localparam logic [ADDR_W-1:0]  INT_VEC   = 16'h00F0;
  localparam logic [INSTR_W-1:0] NOP       = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    IN_ISR = 1'b1
  } fetch_state_e;

  // IF/ID pipeline register contents; bubble marks an injected NOP
  typedef struct packed {
    logic [INSTR_W-1:0] ins;
    logic [ADDR_W-1:0]  addr;
    logic               bubble;
  } ifid_t;

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a
// rising-edge detector; edge_c is high for one cycle per synchronized rise.
module int_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_c
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
    end
  end

  assign edge_c = sync_q[1] & ~prev_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns PC/EPC, drives program memory, fills the
// IF/ID register and handles stall, branch redirect and interrupt entry/return.
module if_fetch_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        reti,
  input  logic        interrupt,
  input  logic [31:0] pm_data,
  output logic [15:0] pm_addr,
  output logic [31:0] ins,
  output logic [15:0] Current_Address,
  output logic        stall_pm,
  output logic        int_ack
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              pending_q, pending_d;
  logic              int_ack_q, int_ack_d;
  ifid_t             ifid_q, ifid_d;
  logic              irq_edge_c;
  logic              pending_c;

  int_sync_edge u_int_sync (
    .clk     (clk),
    .rst_n   (reset),
    .async_i (interrupt),
    .edge_c  (irq_edge_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      pending_q <= 1'b0;
      int_ack_q <= 1'b0;
      ifid_q    <= '{ins: NOP, addr: '0, bubble: 1'b1};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      pending_q <= pending_d;
      int_ack_q <= int_ack_d;
      ifid_q    <= ifid_d;
    end
  end

  // A fresh edge counts as pending this cycle so entry can happen immediately
  assign pending_c = pending_q | irq_edge_c;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    pending_d = pending_c;
    int_ack_d = 1'b0;
    ifid_d    = ifid_q;

    if (branch_taken) begin
      pc_d          = branch_target;
      ifid_d.ins    = NOP;
      ifid_d.bubble = 1'b1;
    end else if (reti && (state_q == IN_ISR)) begin
      pc_d          = epc_q;
      ifid_d.ins    = NOP;
      ifid_d.bubble = 1'b1;
      state_d       = RUN;
    end else if (pending_c && (state_q == RUN) && !stall) begin
      epc_d         = pc_q;
      pc_d          = INT_VEC;
      ifid_d.ins    = NOP;
      ifid_d.bubble = 1'b1;
      int_ack_d     = 1'b1;
      pending_d     = 1'b0;
      state_d       = IN_ISR;
    end else if (!stall) begin
      ifid_d.ins    = pm_data;
      ifid_d.addr   = pc_q;
      ifid_d.bubble = 1'b0;
      pc_d          = pc_q + ADDR_W'(1);
    end
  end

  assign pm_addr         = pc_q;
  assign ins             = ifid_q.ins;
  assign Current_Address = ifid_q.addr;
  assign stall_pm        = ifid_q.bubble;
  assign int_ack         = int_ack_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        reti = 1'b0;
  logic        interrupt = 1'b0;
  logic [31:0] pm_data;
  logic [15:0] pm_addr;
  logic [31:0] ins;
  logic [15:0] Current_Address;
  logic        stall_pm;
  logic        int_ack;

  int tests = 0;
  int fails = 0;

  if_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .reti            (reti),
    .interrupt       (interrupt),
    .pm_data         (pm_data),
    .pm_addr         (pm_addr),
    .ins             (ins),
    .Current_Address (Current_Address),
    .stall_pm        (stall_pm),
    .int_ack         (int_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 32'h1111_0000;
    if (a == 16'h0001) return 32'h2222_0001;
    return {~a, a};
  endfunction

  assign pm_data = mem_word(pm_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: interrupt samples taken at each edge; a rise becomes
  // visible to the fetch logic two edges after it was first sampled.
  logic [15:0] m_pc, m_epc, m_ca;
  logic [31:0] m_ins;
  logic        m_isr, m_pend, m_spm, m_ack;
  logic        h1, h2, h3;

  always @(posedge clk or negedge reset) begin : model
    logic [15:0] n_pc, n_epc, n_ca;
    logic [31:0] n_ins;
    logic        n_isr, n_pend, n_spm, n_ack, rise, want;
    if (!reset) begin
      m_pc <= 16'h0000; m_epc <= 16'h0000; m_ca <= 16'h0000;
      m_ins <= 32'h0; m_isr <= 1'b0; m_pend <= 1'b0; m_spm <= 1'b1; m_ack <= 1'b0;
      h1 <= 1'b0; h2 <= 1'b0; h3 <= 1'b0;
    end else begin
      rise = h2 & ~h3;
      want = m_pend | rise;
      n_pc = m_pc; n_epc = m_epc; n_ca = m_ca; n_ins = m_ins;
      n_isr = m_isr; n_spm = m_spm; n_ack = 1'b0; n_pend = want;
      if (branch_taken) begin
        n_pc = branch_target; n_ins = 32'h0; n_spm = 1'b1;
      end else if (reti && m_isr) begin
        n_pc = m_epc; n_ins = 32'h0; n_spm = 1'b1; n_isr = 1'b0;
      end else if (want && !m_isr && !stall) begin
        n_epc = m_pc; n_pc = 16'h00F0; n_ins = 32'h0; n_spm = 1'b1;
        n_ack = 1'b1; n_pend = 1'b0; n_isr = 1'b1;
      end else if (!stall) begin
        n_ins = mem_word(m_pc); n_ca = m_pc; n_spm = 1'b0; n_pc = m_pc + 16'd1;
      end
      m_pc <= n_pc; m_epc <= n_epc; m_ca <= n_ca; m_ins <= n_ins;
      m_isr <= n_isr; m_spm <= n_spm; m_ack <= n_ack; m_pend <= n_pend;
      h3 <= h2; h2 <= h1; h1 <= interrupt;
    end
  end

  always @(negedge clk) begin
    chk("model_pm_addr", 32'(pm_addr), 32'(m_pc));
    chk("model_ins", ins, m_ins);
    chk("model_stall_pm", 32'(stall_pm), 32'(m_spm));
    chk("model_int_ack", 32'(int_ack), 32'(m_ack));
    if (!m_spm) chk("model_cur_addr", 32'(Current_Address), 32'(m_ca));
  end

  initial begin
    int got;
    int acks;
    #100;
    chk("rst_stall_pm", 32'(stall_pm), 32'd1);
    chk("rst_ins", ins, 32'h0);
    chk("rst_cur_addr", 32'(Current_Address), 32'h0);
    chk("rst_pm_addr", 32'(pm_addr), 32'h0);
    #102 reset = 1'b1;

    @(negedge clk);
    chk("first_ins", ins, 32'h1111_0000);
    chk("first_cur_addr", 32'(Current_Address), 32'h0);
    chk("first_stall_pm", 32'(stall_pm), 32'd0);
    @(negedge clk);
    chk("second_cur_addr", 32'(Current_Address), 32'h1);

    repeat (3) @(negedge clk);
    chk("pc_at_5", 32'(pm_addr), 32'h5);
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_pm_addr", 32'(pm_addr), 32'h5);
      chk("stall_cur_addr", 32'(Current_Address), 32'h4);
      chk("stall_ins", ins, 32'hFFFB_0004);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("post_stall_cur_addr", 32'(Current_Address), 32'h5);

    repeat (2) @(negedge clk);
    chk("pc_at_8", 32'(pm_addr), 32'h8);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
    @(negedge clk);
    stall = 1'b0; branch_taken = 1'b0;
    chk("branch_pm_addr", 32'(pm_addr), 32'h40);
    chk("branch_bubble", 32'(stall_pm), 32'd1);
    @(negedge clk);
    chk("branch_cur_addr", 32'(Current_Address), 32'h40);
    chk("branch_bubble_end", 32'(stall_pm), 32'd0);

    branch_taken = 1'b1; branch_target = 16'h0010;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("pc_at_10", 32'(pm_addr), 32'h10);
    interrupt = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("irq_no_early_ack", 32'(int_ack), 32'd0);
    end
    @(negedge clk);
    chk("irq_ack", 32'(int_ack), 32'd1);
    chk("irq_vector", 32'(pm_addr), 32'hF0);
    interrupt = 1'b0;
    @(negedge clk);
    chk("irq_ack_one_cycle", 32'(int_ack), 32'd0);
    interrupt = 1'b1;
    repeat (4) @(negedge clk);
    chk("isr_no_nesting", 32'(pm_addr), 32'hF5);
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    chk("reti_resume", 32'(pm_addr), 32'h12);
    chk("reti_bubble", 32'(stall_pm), 32'd1);
    @(negedge clk);
    chk("second_irq_ack", 32'(int_ack), 32'd1);
    chk("second_irq_vector", 32'(pm_addr), 32'hF0);
    interrupt = 1'b0;
    @(negedge clk);
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    chk("reti2_resume", 32'(pm_addr), 32'h12);

    branch_taken = 1'b1; branch_target = 16'hFFFF;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("pc_at_ffff", 32'(pm_addr), 32'hFFFF);
    @(negedge clk);
    chk("wrap_pm_addr", 32'(pm_addr), 32'h0);
    chk("wrap_cur_addr", 32'(Current_Address), 32'hFFFF);

    interrupt = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      @(negedge clk);
      if (int_ack) got = 1;
    end
    chk("isr_entry_seen", 32'(got), 32'd1);
    interrupt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("isr_reset_pc", 32'(pm_addr), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("after_reset_pc", 32'(pm_addr), 32'h1);
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    chk("reti_ignored_in_run", 32'(pm_addr), 32'h2);
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (int_ack) acks++;
    end
    chk("no_ack_after_reset", 32'(acks), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset         = ($urandom_range(0, 499) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = 16'($urandom);
      reti          = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) interrupt = ~interrupt;
    end
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; reti = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
